// File: rtl/link_period_meter.sv
// Reference period meter: measures the `link` period in clk cycles, averages it over
// 2^AVG_LOG2 periods, qualifies stability for the PLL and flags loss of the reference.
module link_period_meter #(
  parameter int unsigned AVG_LOG2   = 3,
  parameter int unsigned MIN_PERIOD = 1000,
  parameter int unsigned MAX_PERIOD = 5000,
  parameter int unsigned TOL        = 4,
  parameter int unsigned STABLE_CNT = 2
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        swiptAlive,
  input  logic        link,
  output logic [31:0] period_avg,
  output logic        meas_valid,
  output logic        freq_rdy,
  output logic        link_lost
);

  localparam int unsigned AccW       = 32 + AVG_LOG2;
  localparam int unsigned CntW       = AVG_LOG2 + 1;
  localparam int unsigned NumSamples = 2 ** AVG_LOG2;
  localparam int unsigned StabW      = $clog2(STABLE_CNT + 1);

  typedef logic [CntW-1:0]  cnt_t;
  typedef logic [StabW-1:0] stab_t;

  localparam cnt_t        LastSample = cnt_t'(NumSamples - 1);
  localparam stab_t       StableMax  = stab_t'(STABLE_CNT);
  localparam logic [31:0] MinP       = 32'(MIN_PERIOD);
  localparam logic [31:0] MaxP       = 32'(MAX_PERIOD);
  localparam logic [31:0] TolV       = 32'(TOL);

  typedef enum logic [1:0] {
    StIdle,
    StSync,
    StMeasure
  } state_e;

  state_e          state_q;
  logic            s1_q, s2_q, s3_q;
  logic [31:0]     pcnt_q;
  logic [AccW-1:0] acc_q;
  cnt_t            scnt_q;
  stab_t           stab_q;
  logic            have_prev_q;
  logic [31:0]     period_avg_q;
  logic            meas_valid_q;
  logic            freq_rdy_q;
  logic            link_lost_q;

  logic            rise;
  logic            timeout;
  logic            accept;
  logic            last_sample;
  logic [AccW-1:0] sum_d;
  logic [31:0]     avg_d;
  logic [31:0]     diff;
  logic            within_tol;
  stab_t           stab_inc;
  logic [31:0]     pcnt_inc;

  always_comb begin
    rise        = s2_q & ~s3_q;
    // A rise coinciding with the saturated counter is a timeout, not a sample.
    timeout     = (pcnt_q >= MaxP);
    accept      = rise & ~timeout & (pcnt_q >= MinP);
    last_sample = (scnt_q == LastSample);
    sum_d       = acc_q + AccW'(pcnt_q);
    avg_d       = 32'(sum_d >> AVG_LOG2);
    diff        = (avg_d >= period_avg_q) ? (avg_d - period_avg_q) : (period_avg_q - avg_d);
    within_tol  = have_prev_q & (diff <= TolV);
    stab_inc    = (stab_q >= StableMax) ? StableMax : stab_q + 1'b1;
    pcnt_inc    = timeout ? MaxP : pcnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!nrst || !swiptAlive) begin
      state_q      <= StIdle;
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      s3_q         <= 1'b0;
      pcnt_q       <= '0;
      acc_q        <= '0;
      scnt_q       <= '0;
      stab_q       <= '0;
      have_prev_q  <= 1'b0;
      meas_valid_q <= 1'b0;
      freq_rdy_q   <= 1'b0;
      link_lost_q  <= 1'b0;
      // A soft reset keeps the last average so the PLL seed survives a power blip.
      if (!nrst) begin
        period_avg_q <= '0;
      end
    end else begin
      s1_q         <= link;
      s2_q         <= s1_q;
      s3_q         <= s2_q;
      meas_valid_q <= 1'b0;
      pcnt_q       <= pcnt_inc;
      case (state_q)
        StIdle: begin
          state_q <= StSync;
        end
        StSync: begin
          if (rise) begin
            pcnt_q      <= 32'd1;
            link_lost_q <= 1'b0;
            state_q     <= StMeasure;
          end
        end
        StMeasure: begin
          if (timeout) begin
            link_lost_q <= 1'b1;
            freq_rdy_q  <= 1'b0;
            acc_q       <= '0;
            scnt_q      <= '0;
            stab_q      <= '0;
            have_prev_q <= 1'b0;
            state_q     <= StSync;
          end else if (accept) begin
            pcnt_q <= 32'd1;
            if (last_sample) begin
              period_avg_q <= avg_d;
              meas_valid_q <= 1'b1;
              acc_q        <= '0;
              scnt_q       <= '0;
              have_prev_q  <= 1'b1;
              if (within_tol) begin
                stab_q <= stab_inc;
                if (stab_inc == StableMax) begin
                  freq_rdy_q <= 1'b1;
                end
              end else begin
                stab_q     <= '0;
                freq_rdy_q <= 1'b0;
              end
            end else begin
              acc_q  <= sum_d;
              scnt_q <= scnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign period_avg = period_avg_q;
  assign meas_valid = meas_valid_q;
  assign freq_rdy   = freq_rdy_q;
  assign link_lost  = link_lost_q;

endmodule

// File: tb/tb_link_period_meter.sv
// Bench for link_period_meter: interval-based reference model plus directed and random scenarios,
// run with scaled periods (MIN 100, MAX 500, P 244) to keep the run short.
module tb_link_period_meter;

  localparam int unsigned AVG_LOG2   = 3;
  localparam int unsigned MIN_P      = 100;
  localparam int unsigned MAX_P      = 500;
  localparam int unsigned TOL        = 4;
  localparam int unsigned STABLE_CNT = 2;
  localparam int unsigned NSAMP      = 8;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        swiptAlive = 1'b1;
  logic        link = 1'b0;
  logic [31:0] period_avg;
  logic        meas_valid;
  logic        freq_rdy;
  logic        link_lost;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  link_period_meter #(
    .AVG_LOG2  (AVG_LOG2),
    .MIN_PERIOD(MIN_P),
    .MAX_PERIOD(MAX_P),
    .TOL       (TOL),
    .STABLE_CNT(STABLE_CNT)
  ) dut (
    .clk       (clk),
    .nrst      (nrst),
    .swiptAlive(swiptAlive),
    .link      (link),
    .period_avg(period_avg),
    .meas_valid(meas_valid),
    .freq_rdy  (freq_rdy),
    .link_lost (link_lost)
  );

  // Reference model: works on edge indices and rise-to-rise intervals.
  int          m_n = 0;
  int          m_L = 0;
  int          m_mode = 0;  // 0 idle, 1 waiting for first rise, 2 measuring
  bit          h0, h1, h2;  // link as sampled 1, 2, 3 edges ago
  int unsigned m_samp[$];
  bit          m_have_prev = 0;
  int          m_stab = 0;
  logic [31:0] e_avg = '0;
  logic        e_mv = 1'b0, e_rdy = 1'b0, e_lost = 1'b0;

  task automatic model_edge();
    bit rise;
    int unsigned sum, avg, d;
    m_n++;
    if (!nrst || !swiptAlive) begin
      if (!nrst) e_avg = '0;
      e_mv = 0; e_rdy = 0; e_lost = 0;
      m_mode = 0; h0 = 0; h1 = 0; h2 = 0;
      m_samp.delete(); m_have_prev = 0; m_stab = 0;
    end else begin
      rise = h1 && !h2;
      e_mv = 0;
      if (m_mode == 0) begin
        m_mode = 1;
      end else if (m_mode == 1) begin
        if (rise) begin m_L = m_n; e_lost = 0; m_mode = 2; end
      end else if (m_n - m_L >= int'(MAX_P)) begin
        e_lost = 1; e_rdy = 0; m_samp.delete(); m_stab = 0; m_have_prev = 0; m_mode = 1;
      end else if (rise && (m_n - m_L >= int'(MIN_P))) begin
        m_samp.push_back(m_n - m_L);
        m_L = m_n;
        if (m_samp.size() == NSAMP) begin
          sum = 0;
          foreach (m_samp[i]) sum += m_samp[i];
          avg = sum / NSAMP;
          d = (avg > e_avg) ? avg - e_avg : e_avg - avg;
          if (m_have_prev && d <= TOL) begin
            if (m_stab < STABLE_CNT) m_stab++;
            if (m_stab == STABLE_CNT) e_rdy = 1;
          end else begin
            m_stab = 0; e_rdy = 0;
          end
          e_avg = avg; e_mv = 1; m_have_prev = 1;
          m_samp.delete();
        end
      end
      h2 = h1; h1 = h0; h0 = link;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_edge();
  end

  // Link waveform generator state.
  int g_ph = 0, g_p = 244, g_base = 244, g_jit = 0, g_notch = 0;
  bit g_hold = 1;

  task automatic drive_link();
    if (g_hold) begin
      link = 1'b0;
      g_ph = 0;
    end else begin
      link = (g_ph < g_p / 2) && !(g_notch != 0 && g_ph >= g_notch - 20 && g_ph < g_notch);
      g_ph++;
      if (g_ph >= g_p) begin
        g_ph = 0;
        g_p  = g_base + ((g_jit != 0) ? int'($urandom_range(0, g_jit)) : 0);
      end
    end
  endtask

  bit   ev;
  logic p_rdy, p_lost, pe_rdy, pe_lost;

  task automatic step();
    @(negedge clk);
    ev = meas_valid || e_mv || (freq_rdy !== p_rdy) || (link_lost !== p_lost) ||
         (e_rdy !== pe_rdy) || (e_lost !== pe_lost);
    p_rdy = freq_rdy; p_lost = link_lost; pe_rdy = e_rdy; pe_lost = e_lost;
    drive_link();
  endtask

  task automatic test_reset();
    nrst = 1'b0; swiptAlive = 1'b1; g_hold = 1;
    repeat (5) step();
    total++; if (period_avg !== 32'd0) begin bad++; $display("FAIL reset_avg got=%0d want=0", period_avg); end
    total++; if (meas_valid !== 1'b0) begin bad++; $display("FAIL reset_mv got=%b want=0", meas_valid); end
    total++; if (freq_rdy !== 1'b0) begin bad++; $display("FAIL reset_rdy got=%b want=0", freq_rdy); end
    total++; if (link_lost !== 1'b0) begin bad++; $display("FAIL reset_lost got=%b want=0", link_lost); end
    nrst = 1'b1;
  endtask

  task automatic test_lock();
    int nmv = 0, cyc = 0;
    g_base = 244; g_p = 244; g_jit = 0; g_notch = 0; g_hold = 0;
    while (freq_rdy !== 1'b1 && cyc < 40 * 244) begin
      step(); cyc++;
      if (ev) begin
        total++;
        if ({period_avg, meas_valid, freq_rdy, link_lost} !== {e_avg, e_mv, e_rdy, e_lost}) begin
          bad++;
          $display("FAIL lock_model t=%0t got %0d/%b/%b/%b want %0d/%b/%b/%b", $time, period_avg,
                   meas_valid, freq_rdy, link_lost, e_avg, e_mv, e_rdy, e_lost);
        end
      end
      if (meas_valid === 1'b1) begin
        nmv++; total++;
        if (period_avg !== 32'd244) begin bad++; $display("FAIL lock_avg got=%0d want=244", period_avg); end
      end
    end
    total++; if (freq_rdy !== 1'b1) begin bad++; $display("FAIL lock_timeout rdy=%b want=1", freq_rdy); end
    total++; if (nmv != 3) begin bad++; $display("FAIL lock_avg_count got=%0d want=3", nmv); end
    total++; if (link_lost !== 1'b0) begin bad++; $display("FAIL lock_lost got=%b want=0", link_lost); end
  endtask

  task automatic test_drift();
    int nmv = 0, cyc = 0;
    g_base = 264;
    while (!(nmv >= 1 && freq_rdy === 1'b1) && cyc < 40 * 264) begin
      step(); cyc++;
      if (ev) begin
        total++;
        if ({period_avg, meas_valid, freq_rdy, link_lost} !== {e_avg, e_mv, e_rdy, e_lost}) begin
          bad++;
          $display("FAIL drift_model t=%0t got %0d/%b/%b/%b want %0d/%b/%b/%b", $time, period_avg,
                   meas_valid, freq_rdy, link_lost, e_avg, e_mv, e_rdy, e_lost);
        end
      end
      if (meas_valid === 1'b1) begin
        nmv++;
        if (nmv == 1) begin
          total++;
          if (!(period_avg > 32'd244 && period_avg < 32'd264) || freq_rdy !== 1'b0) begin
            bad++;
            $display("FAIL drift_first got avg=%0d rdy=%b want 244<avg<264 rdy=0", period_avg, freq_rdy);
          end
        end
      end
    end
    total++; if (freq_rdy !== 1'b1) begin bad++; $display("FAIL drift_relock rdy=%b want=1", freq_rdy); end
    total++; if (nmv != 3) begin bad++; $display("FAIL drift_avg_count got=%0d want=3", nmv); end
    total++; if (period_avg !== 32'd264) begin bad++; $display("FAIL drift_avg got=%0d want=264", period_avg); end
  endtask

  task automatic test_glitch();
    int nmv = 0, cyc = 0;
    bit dropped = 0;
    g_base = 244;
    while (!(nmv >= 1 && freq_rdy === 1'b1) && cyc < 40 * 264) begin
      step(); cyc++;
      if (ev) begin
        total++;
        if ({period_avg, meas_valid, freq_rdy, link_lost} !== {e_avg, e_mv, e_rdy, e_lost}) begin
          bad++;
          $display("FAIL glitch_relock_model t=%0t got %0d/%b/%b/%b want %0d/%b/%b/%b", $time,
                   period_avg, meas_valid, freq_rdy, link_lost, e_avg, e_mv, e_rdy, e_lost);
        end
      end
      if (meas_valid === 1'b1) nmv++;
    end
    total++; if (freq_rdy !== 1'b1) begin bad++; $display("FAIL glitch_prelock rdy=%b want=1", freq_rdy); end
    g_notch = 50; nmv = 0;
    repeat (10 * 244) begin
      step();
      if (ev) begin
        total++;
        if ({period_avg, meas_valid, freq_rdy, link_lost} !== {e_avg, e_mv, e_rdy, e_lost}) begin
          bad++;
          $display("FAIL glitch_model t=%0t got %0d/%b/%b/%b want %0d/%b/%b/%b", $time, period_avg,
                   meas_valid, freq_rdy, link_lost, e_avg, e_mv, e_rdy, e_lost);
        end
      end
      if (freq_rdy !== 1'b1) dropped = 1;
      if (meas_valid === 1'b1) begin
        nmv++; total++;
        if (period_avg !== 32'd244) begin bad++; $display("FAIL glitch_avg got=%0d want=244", period_avg); end
      end
    end
    g_notch = 0;
    total++; if (dropped) begin bad++; $display("FAIL glitch_rdy_held got=dropped want=held"); end
    total++; if (nmv < 1) begin bad++; $display("FAIL glitch_avg_count got=%0d want>=1", nmv); end
  endtask

  task automatic test_link_loss();
    int cyc = 0, nmv = 0;
    g_hold = 1;
    while (link_lost !== 1'b1 && cyc < 2 * MAX_P) begin
      step(); cyc++;
      if (ev) begin
        total++;
        if ({period_avg, meas_valid, freq_rdy, link_lost} !== {e_avg, e_mv, e_rdy, e_lost}) begin
          bad++;
          $display("FAIL loss_model t=%0t got %0d/%b/%b/%b want %0d/%b/%b/%b", $time, period_avg,
                   meas_valid, freq_rdy, link_lost, e_avg, e_mv, e_rdy, e_lost);
        end
      end
    end
    total++; if (link_lost !== 1'b1) begin bad++; $display("FAIL loss_flag got=%b want=1", link_lost); end
    total++;
    if (m_n != m_L + int'(MAX_P)) begin
      bad++; $display("FAIL loss_timing got=%0d want=%0d edges after rise", m_n - m_L, MAX_P);
    end
    total++; if (freq_rdy !== 1'b0) begin bad++; $display("FAIL loss_rdy got=%b want=0", freq_rdy); end
    total++; if (period_avg !== 32'd244) begin bad++; $display("FAIL loss_avg got=%0d want=244", period_avg); end
    g_hold = 0; cyc = 0;
    while (link_lost === 1'b1 && cyc < 20) begin step(); cyc++; end
    total++; if (cyc != 4) begin bad++; $display("FAIL loss_clear_delay got=%0d want=4", cyc); end
    cyc = 0;
    while (freq_rdy !== 1'b1 && cyc < 40 * 244) begin
      step(); cyc++;
      if (ev) begin
        total++;
        if ({period_avg, meas_valid, freq_rdy, link_lost} !== {e_avg, e_mv, e_rdy, e_lost}) begin
          bad++;
          $display("FAIL loss_relock_model t=%0t got %0d/%b/%b/%b want %0d/%b/%b/%b", $time,
                   period_avg, meas_valid, freq_rdy, link_lost, e_avg, e_mv, e_rdy, e_lost);
        end
      end
      if (meas_valid === 1'b1) nmv++;
    end
    total++; if (nmv != 3) begin bad++; $display("FAIL loss_relock_count got=%0d want=3", nmv); end
  endtask

  task automatic test_soft_reset();
    int cyc = 0;
    while (meas_valid !== 1'b1 && cyc < 10 * 244) begin step(); cyc++; end
    while (m_samp.size() != 4 && cyc < 20 * 244) begin step(); cyc++; end
    total++; if (m_samp.size() != 4) begin bad++; $display("FAIL soft_setup got=%0d want=4", m_samp.size()); end
    swiptAlive = 1'b0;
    step();
    total++; if (freq_rdy !== 1'b0) begin bad++; $display("FAIL soft_rdy got=%b want=0", freq_rdy); end
    total++; if (period_avg !== 32'd244) begin bad++; $display("FAIL soft_avg_hold got=%0d want=244", period_avg); end
    total++;
    if (meas_valid !== 1'b0 || link_lost !== 1'b0) begin
      bad++; $display("FAIL soft_flags got mv=%b lost=%b want 0/0", meas_valid, link_lost);
    end
    repeat (5) step();
    cyc = 0;
    while (!(g_ph >= g_p / 2 + 2 && g_ph < g_p - 10) && cyc < 400) begin step(); cyc++; end
    swiptAlive = 1'b1;
    cyc = 0;
    while (meas_valid !== 1'b1 && cyc < 12 * 244) begin
      step(); cyc++;
      if (ev) begin
        total++;
        if ({period_avg, meas_valid, freq_rdy, link_lost} !== {e_avg, e_mv, e_rdy, e_lost}) begin
          bad++;
          $display("FAIL soft_model t=%0t got %0d/%b/%b/%b want %0d/%b/%b/%b", $time, period_avg,
                   meas_valid, freq_rdy, link_lost, e_avg, e_mv, e_rdy, e_lost);
        end
      end
    end
    total++;
    if (meas_valid !== 1'b1 || period_avg !== 32'd244 || freq_rdy !== 1'b0) begin
      bad++;
      $display("FAIL soft_restart got mv=%b avg=%0d rdy=%b want 1/244/0", meas_valid, period_avg, freq_rdy);
    end
  endtask

  task automatic test_reset_priority();
    int cyc = 0;
    bit armed = 0;
    while (!armed && cyc < 12 * 244) begin
      step(); cyc++;
      armed = (m_mode == 2) && (m_samp.size() == NSAMP - 1) && h1 && !h2 &&
              (m_n + 1 - m_L >= int'(MIN_P)) && (m_n + 1 - m_L < int'(MAX_P));
    end
    total++; if (!armed) begin bad++; $display("FAIL prio_setup got=unarmed want=armed"); end
    nrst = 1'b0;
    step();
    total++; if (meas_valid !== 1'b0) begin bad++; $display("FAIL prio_mv got=%b want=0", meas_valid); end
    total++;
    if (period_avg !== 32'd0 || freq_rdy !== 1'b0 || link_lost !== 1'b0) begin
      bad++; $display("FAIL prio_outs got avg=%0d rdy=%b lost=%b want 0/0/0", period_avg, freq_rdy, link_lost);
    end
    repeat (2) step();
    nrst = 1'b1;
  endtask

  task automatic test_random();
    for (int r = 0; r < 2; r++) begin
      int len, drop_at;
      g_base  = int'($urandom_range(110, 300));
      g_jit   = int'($urandom_range(0, 8));
      g_notch = ($urandom_range(0, 1) == 1) ? int'($urandom_range(25, g_base / 2 - 1)) : 0;
      len     = 24 * (g_base + g_jit);
      drop_at = int'($urandom_range(1000, 3000));
      for (int c = 0; c < len; c++) begin
        step();
        if (c == drop_at) swiptAlive = 1'b0;
        if (c == drop_at + 7) swiptAlive = 1'b1;
        if (ev) begin
          total++;
          if ({period_avg, meas_valid, freq_rdy, link_lost} !== {e_avg, e_mv, e_rdy, e_lost}) begin
            bad++;
            $display("FAIL random_model r=%0d t=%0t got %0d/%b/%b/%b want %0d/%b/%b/%b", r, $time,
                     period_avg, meas_valid, freq_rdy, link_lost, e_avg, e_mv, e_rdy, e_lost);
          end
        end
      end
    end
    g_notch = 0; g_jit = 0;
  endtask

  initial begin
    test_reset();
    test_lock();
    test_drift();
    test_glitch();
    test_link_loss();
    test_soft_reset();
    test_reset_priority();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
